// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : asynchronous serial receiver, 8N1, LSB first.
//
// Receives frames on rx and presents each correctly framed byte on po_data with
// a one-cycle po_flag strobe. These two outputs connect directly to a
// transmitter's pi_data/pi_flag. If the stop bit is sampled low, the byte is
// dropped and frame_err pulses for one cycle.
//
// Parameters
//   UART_BPS   line baud rate
//   CLK_FREQ   clk frequency in Hz (CLK_FREQ/UART_BPS must lie in 4..65535)
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active high
//   rx         serial input, asynchronous to clk, idle high
//   po_data    last correctly framed byte, held until the next good frame
//   po_flag    one-cycle strobe: po_data updated this cycle
//   frame_err  one-cycle strobe: stop bit sampled low, byte discarded
//
// Build option
//   RX_MAJORITY_EN : when defined, each bit is the 2-of-3 majority of the
//                    synchronised line at baud_cnt MID-1, MID and MID+1.
//                    Decisions move to MID+1, one cycle later than the
//                    default single sample at MID.
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int UART_BPS = 9600,
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] po_data,
   output logic       po_flag,
   output logic       frame_err
);

   localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
   localparam logic [15:0] MID          = 16'(BAUD_CNT_MAX / 2 - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t      state_r;
   logic        rx_s1_r;
   logic        rx_s2_r;
   logic        rx_s3_r;
   logic [15:0] baud_cnt_r;
   logic [2:0]  bit_cnt_r;
   logic [7:0]  shift_r;
   logic        fall_s;
   logic        tick_s;
   logic        bit_s;

`ifdef RX_MAJORITY_EN
   localparam logic [15:0] MID_M1 = MID - 16'd1;
   localparam logic [15:0] MID_P1 = MID + 16'd1;

   logic maj_a_r;
   logic maj_b_r;

   // 2-of-3 vote used to reject a single-cycle glitch at the sample point
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Capture the two early votes; the third is the live value at MID+1
   always_ff @(posedge clk) begin
      if (rst) begin
         maj_a_r <= 1'b1;
         maj_b_r <= 1'b1;
      end else begin
         if (baud_cnt_r == MID_M1) maj_a_r <= rx_s2_r;
         else                      maj_a_r <= maj_a_r;
         if (baud_cnt_r == MID)    maj_b_r <= rx_s2_r;
         else                      maj_b_r <= maj_b_r;
      end
   end
`endif

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_r <= 1'b1;
         rx_s2_r <= 1'b1;
         rx_s3_r <= 1'b1;
      end else begin
         rx_s1_r <= rx;
         rx_s2_r <= rx_s1_r;
         rx_s3_r <= rx_s2_r;
      end
   end

   // Edge detect, decision point and bit value for the current bit period
   always_comb begin
      fall_s = rx_s3_r & ~rx_s2_r;
      tick_s = 1'b0;
      bit_s  = rx_s2_r;
`ifdef RX_MAJORITY_EN
      tick_s = (baud_cnt_r == MID_P1);
      bit_s  = maj3(maj_a_r, maj_b_r, rx_s2_r);
`else
      tick_s = (baud_cnt_r == MID);
`endif
   end

   // Receive FSM with baud/bit counters and registered output strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         baud_cnt_r <= 16'd0;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
         po_data    <= 8'h00;
         po_flag    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         po_flag   <= 1'b0;
         frame_err <= 1'b0;

         // The counter is held at zero in IDLE, so entry to START always begins at 0
         if (state_r == IDLE)              baud_cnt_r <= 16'd0;
         else if (baud_cnt_r == BAUD_LAST) baud_cnt_r <= 16'd0;
         else                              baud_cnt_r <= baud_cnt_r + 16'd1;

         case (state_r)
            IDLE: begin
               if (fall_s) state_r <= START;
               else        state_r <= IDLE;
            end
            START: begin
               // A line that is high again at mid-start was a glitch: drop it silently
               if (tick_s) begin
                  if (!bit_s) begin
                     state_r   <= DATA;
                     bit_cnt_r <= 3'd0;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= START;
               end
            end
            DATA: begin
               if (tick_s) begin
                  shift_r <= {bit_s, shift_r[7:1]};
                  if (bit_cnt_r == 3'd7) begin
                     state_r <= STOP;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end else begin
                  state_r <= DATA;
               end
            end
            STOP: begin
               // Leave at mid-stop so a back-to-back start edge is not missed
               if (tick_s) begin
                  if (bit_s) begin
                     po_data <= shift_r;
                     po_flag <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state_r <= IDLE;
               end else begin
                  state_r <= STOP;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx : directed self-checking bench for uart_rx.
// A small clock/baud ratio (32 clk per bit, MID = 15) keeps frames short.
// rx is driven on the falling clock edge. Outputs are observed on the falling
// edge by a monitor that counts and logs strobes.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int B   = 32;
   localparam int MID = B / 2 - 1;
`ifdef RX_MAJORITY_EN
   localparam int EXP_LAT = 9 * B + MID + 5;
   localparam logic [7:0] EXP_GLITCH = 8'h0F;
`else
   localparam int EXP_LAT = 9 * B + MID + 4;
   localparam logic [7:0] EXP_GLITCH = 8'h0B;
`endif

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] po_data;
   logic       po_flag;
   logic       frame_err;

   int         n_assert;
   int         n_fail;
   int         cyc;
   int         start_cyc;
   int         flag_n;
   int         err_n;
   int         wide_n;
   int         both_n;
   int         flag_cyc;
   logic       prev_flag;
   logic       prev_err;
   logic [7:0] data_log [0:15];

   uart_rx #(
      .UART_BPS (10_000),
      .CLK_FREQ (320_000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .po_data   (po_data),
      .po_flag   (po_flag),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: counts pulses, logs bytes, flags over-long or overlapping strobes
   always @(negedge clk) begin
      prev_flag <= po_flag;
      prev_err  <= frame_err;
      if (po_flag === 1'b1) begin
         if (flag_n < 16) data_log[flag_n] <= po_data;
         flag_n   <= flag_n + 1;
         flag_cyc <= cyc;
      end
      if (frame_err === 1'b1) err_n <= err_n + 1;
      if (po_flag === 1'b1 && prev_flag === 1'b1) wide_n <= wide_n + 1;
      if (frame_err === 1'b1 && prev_err === 1'b1) wide_n <= wide_n + 1;
      if (po_flag === 1'b1 && frame_err === 1'b1) both_n <= both_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx = 1'b1;
      end
   endtask

   task automatic hold_low(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx = 1'b0;
      end
   endtask

   // One 8N1 frame; optional inverted glitch at mid bit 2, optional reset at data bit 4
   task automatic send_frame(input logic [7:0] d, input logic stop_v,
                             input bit glitch, input bit abort_at_b4);
      logic b;
      bit   done;
      done = 1'b0;
      for (int j = 0; j < 10; j++) begin
         if (j == 0)      b = 1'b0;
         else if (j == 9) b = stop_v;
         else             b = d[j-1];
         for (int c = 0; c < B; c++) begin
            if (!done) begin
               @(negedge clk);
               if (abort_at_b4 && j == 5 && c == 0) begin
                  rst = 1'b1;
                  rx  = 1'b1;
                  @(negedge clk);
                  @(negedge clk);
                  rst  = 1'b0;
                  done = 1'b1;
               end else begin
                  if (j == 0 && c == 0) start_cyc = cyc;
                  if (glitch && j == 3 && c == MID + 1) rx = ~b;
                  else                                  rx = b;
               end
            end
         end
      end
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      cyc       = 0;
      start_cyc = 0;
      flag_n    = 0;
      err_n     = 0;
      wide_n    = 0;
      both_n    = 0;
      flag_cyc  = 0;
      prev_flag = 1'b0;
      prev_err  = 1'b0;
      rst       = 1'b1;
      rx        = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);
      check("reset_po_data", {24'd0, po_data}, 32'h00);
      check("reset_po_flag", {31'd0, po_flag}, 32'h0);
      check("reset_frame_err", {31'd0, frame_err}, 32'h0);
      rst = 1'b0;
      idle(8);

      // 1: plain frame 0x55
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      idle(8);
      check("t1_flag_count", flag_n, 32'd1);
      check("t1_logged_byte", {24'd0, data_log[0]}, 32'h55);
      check("t1_po_data", {24'd0, po_data}, 32'h55);
      check("t1_no_frame_err", err_n, 32'd0);
      check("t1_latency_in_window",
            {31'd0, (flag_cyc - start_cyc >= EXP_LAT - 1) && (flag_cyc - start_cyc <= EXP_LAT + 1)},
            32'd1);

      // 2: short low pulse is rejected as a false start, then 0xA3 is received
      hold_low(6);
      idle(2 * B);
      check("t2_glitch_no_flag", flag_n, 32'd1);
      check("t2_glitch_no_err", err_n, 32'd0);
      send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
      idle(8);
      check("t2_flag_count", flag_n, 32'd2);
      check("t2_po_data", {24'd0, po_data}, 32'hA3);

      // 3: 0x55 then 0xA3 with a low stop bit followed by a break
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
      hold_low(3 * B);
      idle(2 * B);
      check("t3_err_count", err_n, 32'd1);
      check("t3_flag_count", flag_n, 32'd3);
      check("t3_po_data_held", {24'd0, po_data}, 32'h55);

      // 4: back-to-back 0x00 and 0xFF
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      idle(8);
      check("t4_flag_count", flag_n, 32'd5);
      check("t4_first_byte", {24'd0, data_log[3]}, 32'h00);
      check("t4_second_byte", {24'd0, data_log[4]}, 32'hFF);

      // 5: reset during data bit 4, then 0x3C
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      check("t5_rst_po_data", {24'd0, po_data}, 32'h00);
      check("t5_rst_po_flag", {31'd0, po_flag}, 32'h0);
      check("t5_rst_frame_err", {31'd0, frame_err}, 32'h0);
      idle(2 * B);
      check("t5_no_strobe_flag", flag_n, 32'd5);
      check("t5_no_strobe_err", err_n, 32'd1);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      idle(8);
      check("t5_flag_count", flag_n, 32'd6);
      check("t5_po_data", {24'd0, po_data}, 32'h3C);

      // 6: 0x0F with a one-clock inverted glitch at the sample point of bit 2
      send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
      idle(8);
      check("t6_flag_count", flag_n, 32'd7);
      check("t6_po_data", {24'd0, po_data}, {24'd0, EXP_GLITCH});

      check("strobe_width_one_cycle", wide_n, 32'd0);
      check("strobes_never_together", both_n, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
